// File: rtl/tinyalu_dispatch.sv
// TinyALU command front-end: ADD/AND/XOR computed locally, MUL issued to the external 3-cycle multiplier.
// Optional macro TINYALU_DISPATCH_MUL_TIMEOUT_EN adds a MUL_WAIT watchdog of MUL_TIMEOUT cycles.
module tinyalu_dispatch #(
  parameter int MUL_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_done,
  input  logic [15:0] mul_result
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MUL_ISSUE = 2'd1,
    MUL_WAIT  = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] result_r, result_nxt_s;
  logic        err_r, err_nxt_s;
  logic        rsp_valid_r, mul_start_r;
  logic [7:0]  mul_a_r, mul_b_r;
  logic        mul_load_s, accept_s, timeout_s;
  logic [8:0]  sum_s;

  assign req_ready  = (state_r == IDLE) && !rst;
  assign accept_s   = req_valid && req_ready;
  assign sum_s      = {1'b0, req_a} + {1'b0, req_b};
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = result_r;
  assign rsp_err    = err_r;
  assign mul_start  = mul_start_r;
  assign mul_a      = mul_a_r;
  assign mul_b      = mul_b_r;

`ifdef TINYALU_DISPATCH_MUL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(MUL_TIMEOUT - 1);
  logic [7:0] wait_cnt_r, wait_cnt_nxt_s;

  assign timeout_s = (wait_cnt_r == TIMEOUT_LAST);

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 8'd0;
    end else begin
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Counts MUL_WAIT cycles; held at zero elsewhere so every wait starts fresh
  always_comb begin
    wait_cnt_nxt_s = 8'd0;
    if (state_r == MUL_WAIT) begin
      wait_cnt_nxt_s = wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_nxt_s = 8'd0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, response payload and operand-load decode
  always_comb begin
    state_nxt_s  = state_r;
    result_nxt_s = result_r;
    err_nxt_s    = err_r;
    mul_load_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (req_op)
            3'b000: state_nxt_s = IDLE;
            3'b001: begin
              result_nxt_s = {7'd0, sum_s};
              err_nxt_s    = 1'b0;
              state_nxt_s  = RESP;
            end
            3'b010: begin
              result_nxt_s = {8'd0, req_a & req_b};
              err_nxt_s    = 1'b0;
              state_nxt_s  = RESP;
            end
            3'b011: begin
              result_nxt_s = {8'd0, req_a ^ req_b};
              err_nxt_s    = 1'b0;
              state_nxt_s  = RESP;
            end
            3'b100: begin
              mul_load_s  = 1'b1;
              state_nxt_s = MUL_ISSUE;
            end
            default: begin
              result_nxt_s = 16'd0;
              err_nxt_s    = 1'b1;
              state_nxt_s  = RESP;
            end
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL_ISSUE: state_nxt_s = MUL_WAIT;
      MUL_WAIT: begin
        // A done pulse coinciding with watchdog expiry still delivers the product
        if (mul_done) begin
          result_nxt_s = mul_result;
          err_nxt_s    = 1'b0;
          state_nxt_s  = RESP;
        end else if (timeout_s) begin
          result_nxt_s = 16'hFFFF;
          err_nxt_s    = 1'b1;
          state_nxt_s  = RESP;
        end else begin
          state_nxt_s = MUL_WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and registered outputs; strobes are registered from the next state to stay glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      result_r    <= 16'd0;
      err_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      mul_start_r <= 1'b0;
      mul_a_r     <= 8'd0;
      mul_b_r     <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      result_r    <= result_nxt_s;
      err_r       <= err_nxt_s;
      rsp_valid_r <= (state_nxt_s == RESP);
      mul_start_r <= (state_nxt_s == MUL_ISSUE);
      if (mul_load_s) begin
        mul_a_r <= req_a;
        mul_b_r <= req_b;
      end
    end
  end

endmodule

// File: tb/tb_tinyalu_dispatch.sv
// Scoreboard bench for tinyalu_dispatch: random and directed requests, behavioural multiplier model.
`timescale 1ns/1ps
module tb_tinyalu_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [7:0]  req_a = 8'd0;
  logic [7:0]  req_b = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done;
  logic [15:0] mul_result;

  always #5 clk = ~clk;

  tinyalu_dispatch #(.MUL_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result)
  );

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rsp_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: samples operands on the rising edge of mul_start, done pulse three cycles later
  logic        mul_en = 1'b1;
  logic        spur_done = 1'b0;
  logic [15:0] spur_res = 16'd0;
  logic        start_prev = 1'b0;
  logic [2:0]  pipe = 3'd0;
  logic [15:0] prod = 16'd0;

  always @(posedge clk) begin
    start_prev <= mul_start;
    pipe <= {pipe[1:0], mul_start && !start_prev};
    if (mul_start && !start_prev) prod <= {8'd0, mul_a} * {8'd0, mul_b};
  end

  assign mul_done   = (pipe[2] && mul_en) || spur_done;
  assign mul_result = pipe[2] ? prod : spur_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ai;
    int bi;
    ai = a;
    bi = b;
    e.lat = 1;
    e.err = 1'b0;
    e.acc = 0;
    case (op)
      3'd1: e.res = 16'(ai + bi);
      3'd2: e.res = 16'(ai & bi);
      3'd3: e.res = 16'(ai ^ bi);
      3'd4: begin e.res = 16'(ai * bi); e.lat = 5; end
      default: begin e.res = 16'd0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Response consumer
  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = (rsp_mode == 1) || (rsp_mode == 2 && $urandom_range(0, 2) != 0);
  end

  // Monitor: latency, stability under backpressure, scoreboard pop on handshake, mul_start width
  bit          seen = 1'b0;
  logic [15:0] hold_res;
  logic        hold_err;
  int          run = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      seen = 1'b0;
      run  = 0;
    end else begin
      if (mul_start) run++;
      else if (run > 0) begin
        check("mul_start_width", run, 1);
        run = 0;
      end
      if (rsp_valid) begin
        check("req_ready_in_resp", {31'd0, req_ready}, 0);
        if (q.size() == 0) begin
          check("unexpected_rsp", {31'd0, rsp_valid}, 0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            hold_res = rsp_result;
            hold_err = rsp_err;
            if (q[0].lat >= 0) check("latency", cyc - q[0].acc, q[0].lat);
          end else begin
            check("hold_result", {16'd0, rsp_result}, {16'd0, hold_res});
            check("hold_err", {31'd0, rsp_err}, {31'd0, hold_err});
          end
          if (rsp_ready) begin
            check("result", {16'd0, rsp_result}, {16'd0, q[0].res});
            check("err", {31'd0, rsp_err}, {31'd0, q[0].err});
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int lat);
    exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {31'd0, req_ready}, 1);
    end else begin
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      if (op != 3'd0) begin
        e = model(op, a, b);
        if (lat != 0) e.lat = lat;
        e.acc = cyc;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op = 3'($urandom_range(0, 7));
      req_a = 8'($urandom);
      req_b = 8'($urandom);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((q.size() != 0 || !req_ready) && t < 300);
    check("drain_pending", q.size(), 0);
  endtask

  task automatic spur_pulse(input logic [15:0] r);
    @(negedge clk);
    spur_res = r;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp_result", {16'd0, rsp_result}, 0);
    check("rst_rsp_err", {31'd0, rsp_err}, 0);
    check("rst_mul_start", {31'd0, mul_start}, 0);
    check("rst_mul_a", {24'd0, mul_a}, 0);
    check("rst_mul_b", {24'd0, mul_b}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    rsp_mode = 1;
    issue(3'd1, 8'hFF, 8'h01, 0);
    drain();
    issue(3'd4, 8'h0C, 8'h0D, 0);
    drain();
    issue(3'd4, 8'hFF, 8'hFF, 0);
    drain();

    // XOR under 10 cycles of backpressure
    rsp_mode = 0;
    issue(3'd3, 8'hA5, 8'h0F, 0);
    repeat (10) @(negedge clk);
    check("xor_still_valid", {31'd0, rsp_valid}, 1);
    rsp_mode = 1;
    drain();

    issue(3'd6, 8'h12, 8'h34, 0);
    drain();
    issue(3'd0, 8'h55, 8'h66, 0);
    repeat (3) begin
      @(negedge clk);
      check("nop_ready", {31'd0, req_ready}, 1);
      check("nop_no_rsp", {31'd0, rsp_valid}, 0);
    end

    // Multiplier that never answers
    mul_en = 1'b0;
`ifdef TINYALU_DISPATCH_MUL_TIMEOUT_EN
    issue(3'd4, 8'h11, 8'h22, 10);
    q[q.size() - 1].res = 16'hFFFF;
    q[q.size() - 1].err = 1'b1;
    drain();
    spur_pulse(16'h5A5A);
    repeat (5) begin
      @(negedge clk);
      check("late_done_ignored", {31'd0, rsp_valid}, 0);
    end
`else
    issue(3'd4, 8'h11, 8'h22, -1);
    repeat (20) begin
      @(negedge clk);
      check("mul_wait_forever", {31'd0, rsp_valid}, 0);
    end
    spur_pulse(16'h0242);
    drain();
`endif

    // Reset while waiting on the multiplier
    issue(3'd4, 8'h21, 8'h43, -1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("midrst_req_ready", {31'd0, req_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_mul_start", {31'd0, mul_start}, 0);
    check("postrst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("postrst_req_ready", {31'd0, req_ready}, 1);
    spur_pulse(16'h1234);
    repeat (5) begin
      @(negedge clk);
      check("stale_done_ignored", {31'd0, rsp_valid}, 0);
    end
    mul_en = 1'b1;

    // Randomized traffic with random backpressure
    rsp_mode = 2;
    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
